// File: rtl/control_unit_fsm.sv
// Multicycle control unit: sequences e/s0/s1/s2 per mode, pulses done.
// Outputs are registered from the next-state decode, so they track state.
module control_unit_fsm (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic mode,
  output logic e,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    C1   = 3'd2,
    C2   = 3'd3,
    C3   = 3'd4,
    C4   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t state;
  state_t nxt;
  logic   mode_r;
  logic [4:0] nxt_out;

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = C1;
      C1:      nxt = C2;
      C2:      nxt = mode_r ? C3 : DONE;
      C3:      nxt = C4;
      C4:      nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // {e,s0,s1,s2,done} for the state being entered
  always_comb begin
    nxt_out = 5'b00000;
    unique case (nxt)
      LOAD:    nxt_out = 5'b11000;
      C1:      nxt_out = 5'b10100;
      C2:      nxt_out = 5'b10010;
      C3:      nxt_out = 5'b10110;
      C4:      nxt_out = 5'b11100;
      DONE:    nxt_out = 5'b00001;
      default: nxt_out = 5'b00000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mode_r <= 1'b0;
      e      <= 1'b0;
      s0     <= 1'b0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start)
        mode_r <= mode;
      {e, s0, s1, s2, done} <= nxt_out;
    end
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed table-driven bench for control_unit_fsm.
// Vectors: inputs applied before an edge, outputs checked just after it.
module tb_control_unit_fsm;

  logic clock;
  logic reset;
  logic start;
  logic mode;
  logic e, s0, s1, s2, done;

  int checks;
  int errors;

  control_unit_fsm dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .mode (mode),
    .e    (e),
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .done (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       md;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t m1[$];

  function automatic logic [4:0] outs();
    return {e, s0, s1, s2, done};
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (e,s0,s1,s2,done)",
               name, outs(), exp);
    end
  endtask

  task automatic step(input logic st, input logic md,
                      input logic [4:0] exp, input string name);
    @(negedge clock);
    start = st;
    mode  = md;
    @(posedge clock);
    #1;
    check(name, exp);
  endtask

  function automatic vec_t v(input logic st, input logic md,
                             input logic [4:0] exp);
    vec_t r;
    r.st  = st;
    r.md  = md;
    r.exp = exp;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // mode 0
    tbl.push_back(v(1, 0, 5'b11000));
    tbl.push_back(v(0, 0, 5'b10100));
    tbl.push_back(v(0, 0, 5'b10010));
    tbl.push_back(v(0, 0, 5'b00001));
    tbl.push_back(v(0, 0, 5'b00000));
    tbl.push_back(v(0, 0, 5'b00000));
    // mode 1
    tbl.push_back(v(1, 1, 5'b11000));
    tbl.push_back(v(0, 0, 5'b10100));
    tbl.push_back(v(0, 0, 5'b10010));
    tbl.push_back(v(0, 0, 5'b10110));
    tbl.push_back(v(0, 0, 5'b11100));
    tbl.push_back(v(0, 0, 5'b00001));
    tbl.push_back(v(0, 0, 5'b00000));
    // mode flip in LOAD: short path kept
    tbl.push_back(v(1, 0, 5'b11000));
    tbl.push_back(v(0, 1, 5'b10100));
    tbl.push_back(v(0, 1, 5'b10010));
    tbl.push_back(v(0, 1, 5'b00001));
    tbl.push_back(v(0, 1, 5'b00000));
    // start held high, mode 0
    tbl.push_back(v(1, 0, 5'b11000));
    tbl.push_back(v(1, 0, 5'b10100));
    tbl.push_back(v(1, 0, 5'b10010));
    tbl.push_back(v(1, 0, 5'b00001));
    tbl.push_back(v(1, 0, 5'b00000));
    tbl.push_back(v(1, 0, 5'b11000));
    tbl.push_back(v(1, 0, 5'b10100));
    tbl.push_back(v(1, 0, 5'b10010));
    tbl.push_back(v(1, 0, 5'b00001));
    tbl.push_back(v(0, 0, 5'b00000));
    tbl.push_back(v(0, 0, 5'b00000));

    m1.push_back(v(1, 1, 5'b11000));
    m1.push_back(v(0, 0, 5'b10100));
    m1.push_back(v(0, 0, 5'b10010));
    m1.push_back(v(0, 0, 5'b10110));
    m1.push_back(v(0, 0, 5'b11100));
    m1.push_back(v(0, 0, 5'b00001));
    m1.push_back(v(0, 0, 5'b00000));

    // reset held low with start high, no edge needed
    reset = 1'b0;
    start = 1'b1;
    mode  = 1'b1;
    #1;
    check("reset_no_edge", 5'b00000);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", 5'b00000);

    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;

    foreach (tbl[i])
      step(tbl[i].st, tbl[i].md, tbl[i].exp,
           $sformatf("vec%0d", i));

    // abort during C3 of mode 1
    for (int i = 0; i < 4; i++)
      step(m1[i].st, m1[i].md, m1[i].exp,
           $sformatf("abort_pre%0d", i));
    #2;
    reset = 1'b0;
    #1;
    check("abort_async", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("abort_hold%0d", i), 5'b00000);
    end
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 5'b00000, "abort_idle");
    foreach (m1[i])
      step(m1[i].st, m1[i].md, m1[i].exp,
           $sformatf("post_abort%0d", i));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
# control_unit_fsm

Multicycle control unit for a small shared datapath. It sequences one operation per `start` request, driving register enable `e` and datapath mux selects `s0`/`s1`/`s2` through a fixed per-mode cycle pattern. It pulses `done` when the operation completes. It sits beside the datapath it controls; that datapath consumes `e`/`s*` combinationally on the same clock.

## Interface
- No parameters; state encoding is internal and free to choose.
- `clock`  input  1  single system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `start`  input  1  operation request; level-sampled only in IDLE.
- `mode`  input  1  operation select, captured with `start`: 0 = short (2 compute cycles), 1 = long (4 compute cycles).
- `e`  output  1  datapath register write enable.
- `s0`  output  1  mux select 0 (load external operand).
- `s1`  output  1  mux select 1.
- `s2`  output  1  mux select 2.
- `done`  output  1  one-cycle completion pulse.

## Operation
- Moore machine: all outputs decode from the current state only; no combinational path from `start`/`mode` to any output.
- Internal `mode_r` register is loaded from `mode` on the IDLE→LOAD transition and held for the rest of the operation. Changes on `mode` mid-operation are ignored.
- Each state lists its outputs as e,s0,s1,s2,done, followed by its transition:
  - IDLE: 0,0,0,0,0. If `start`=1 go to LOAD, else stay.
  - LOAD: 1,1,0,0,0. Go to C1.
  - C1: 1,0,1,0,0. Go to C2.
  - C2: 1,0,0,1,0. If `mode_r`=0 go to DONE, else go to C3.
  - C3: 1,0,1,1,0. Go to C4.
  - C4: 1,1,1,0,0. Go to DONE.
  - DONE: 0,0,0,0,1. Go to IDLE unconditionally.
- Any unused or illegal state encoding goes to IDLE on the next edge, with outputs all 0.
- `start` is ignored in every state except IDLE. It is a level, not an edge. If `start` is held high through DONE, a new operation begins from IDLE on the following edge, using the `mode` value at that edge.

## Timing
- Reset: `reset`=0 forces state IDLE and `mode_r`=0 immediately, without waiting for a clock edge. All outputs go to 0 during reset. Release is sampled synchronously; the first transition can occur on the first rising edge with `reset`=1.
- Reset asserted mid-operation aborts the operation at once. No `done` is produced for the aborted request.
- Latency, counting from the rising edge that samples `start`=1 in IDLE (edge 0):
  - Mode 0: LOAD after edge 0, C1 after edge 1, C2 after edge 2, DONE (`done`=1) after edge 3, IDLE after edge 4. `e` is high for exactly 3 cycles.
  - Mode 1: `done`=1 after edge 5, IDLE after edge 6. `e` is high for exactly 5 cycles.
- `done` is high for exactly one clock period per accepted request.
- Minimum request spacing: 5 cycles in mode 0, 7 cycles in mode 1 (DONE always returns through IDLE).
- X/undefined `start` while in IDLE is not legal stimulus.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `start`=1 → all outputs 0 and state IDLE, with no clock edge required.
- Mode 0: release reset, pulse `start`=1, `mode`=0 for one edge → e,s0,s1,s2 sequence 1100, 1010, 1001, then `done`=1 with e=0 in the 4th cycle, then all outputs 0.
- Mode 1: `start`=1, `mode`=1 → sequence 1100, 1010, 1001, 1011, 1110, then `done`=1 in the 6th cycle, then IDLE.
- Mode flip: start with `mode`=0, then set `mode`=1 in the LOAD cycle → short sequence still taken, `done` in the 4th cycle.
- Start held high: `start`=1 continuously with `mode`=0 → `done` pulses every 5 cycles, with one IDLE cycle (all zeros) between operations.
- Abort: drive `reset`=0 asynchronously during C3 of a mode-1 operation → outputs 0 before the next edge, no `done`, and a fresh `start` after release behaves as in the mode 1 scenario.
